digit_serial_addsub: RTL and testbench



---
 rtl/digit_serial_pkg.sv | 30 +++
 rtl/digit_adder.sv | 38 +++
 rtl/digit_serial_addsub.sv | 165 ++++++++++++++++
 tb/tb_digit_serial_addsub.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module  : digit_serial_pkg
// Purpose : Shared types, state encodings and helper function for the
//           digit-serial add/subtract unit.
// Contents: state_e       - symbolic state type (IDLE / RUN / DONE)
//           S_IDLE/S_RUN/S_DONE - explicit 2-bit state encodings used by the FSM
//           cnt_width()   - digit counter width, $clog2(ndig) but never below 1
// Revision: 1.0 - initial release
// ============================================================================
package digit_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // A single-digit configuration still needs a 1-bit counter so the
  // register exists and the last-digit compare stays well formed.
  function automatic int cnt_width(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage : digit_serial_pkg
`default_nettype wire

// File: rtl/digit_adder.sv
`default_nettype none
// ============================================================================
// Module  : digit_adder
// Purpose : DIGIT-bit ripple-carry adder built from one full-adder cell per
//           bit. Purely combinational; reused by the serial unit every cycle.
// Ports   : a_i     [DIGIT-1:0] addend A digit
//           b_i     [DIGIT-1:0] addend B digit
//           c_i                 carry in
//           s_o     [DIGIT-1:0] digit sum
//           c_o                 carry out of the top bit
//           c_msb_o             carry into the top bit (for signed overflow)
// Revision: 1.0 - initial release
// ============================================================================
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] s_o,
  output logic             c_o,
  output logic             c_msb_o
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = c_i;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ w_c[i];
    assign w_c[i+1] = (a_i[i] & b_i[i]) | (w_c[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o     = w_c[DIGIT];
  assign c_msb_o = w_c[DIGIT-1];

endmodule : digit_adder
`default_nettype wire

// File: rtl/digit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module  : digit_serial_addsub
// Purpose : WIDTH-bit adder/subtractor that processes DIGIT bits per clock
//           through a single digit_adder, with start/busy/done handshake,
//           raw carry-out and signed overflow.
// Ports   : clk, rst                 clock, synchronous active-high reset
//           start_i                  request, honoured only while idle
//           sub_i                    0: a+b+cin, 1: a-b-cin (cin = borrow)
//           a_i, b_i   [WIDTH-1:0]   operands, captured on accept
//           cin_i                    carry/borrow in, captured on accept
//           busy_o                   high whenever not idle
//           done_o                   one-cycle result-valid pulse
//           sum_o      [WIDTH-1:0]   result, held until next completion
//           cout_o                   raw MSB carry (sub: 1 = no borrow)
//           ovf_o                    two's-complement overflow
// Revision: 1.0 - initial release
// ============================================================================
module digit_serial_addsub
  import digit_serial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(NDIG);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] w_dsum;
  logic             w_dco;
  logic             w_dmsb;
  logic [WIDTH-1:0] w_full;
  logic             w_last;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .a_i     (a_sh_q[DIGIT-1:0]),
    .b_i     (b_sh_q[DIGIT-1:0]),
    .c_i     (carry_q),
    .s_o     (w_dsum),
    .c_o     (w_dco),
    .c_msb_o (w_dmsb)
  );

  // Partial result: only the WIDTH-DIGIT bits already produced need storing.
  // The final digit is concatenated on the fly on the last RUN edge, so the
  // whole word lands in sum_q on the same edge that enters DONE.
  if (NDIG > 1) begin : g_multi
    logic [WIDTH-DIGIT-1:0] part_q;

    assign w_full = {w_dsum, part_q};

    always_ff @(posedge clk) begin
      if (rst) begin
        part_q <= '0;
      end else if (state_q == S_RUN) begin
        part_q <= w_full[WIDTH-1:DIGIT];
      end
    end
  end else begin : g_single
    assign w_full = w_dsum;
  end

  assign w_last = (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_sh_d  = a_i;
          // Subtraction as a + ~b + ~borrow: a borrow-in of 1 removes the +1
          // that completes the two's complement of b.
          b_sh_d  = sub_i ? ~b_i : b_i;
          carry_d = sub_i ? ~cin_i : cin_i;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        carry_d = w_dco;
        cnt_d   = cnt_q + CNT_W'(1);
        if (w_last) begin
          sum_d   = w_full;
          cout_d  = w_dco;
          ovf_d   = w_dmsb ^ w_dco;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule : digit_serial_addsub
`default_nettype wire

// File: tb/tb_digit_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module  : tb_digit_serial_addsub
// Purpose : Self-checking bench for digit_serial_addsub in three
//           configurations: 16/4, 8/8 and 8/1 (WIDTH/DIGIT).
// Revision: 1.0 - initial release
// ============================================================================
module tb_digit_serial_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a_r, b_r;
  logic        sub_r, cin_r;
  logic        st16, st88, st81;

  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;
  logic        busy88, done88, cout88, ovf88;
  logic [7:0]  sum88;
  logic        busy81, done81, cout81, ovf81;
  logic [7:0]  sum81;

  int total = 0;
  int bad   = 0;
  int cfg_sel = 0;

  logic        sel_busy, sel_done, sel_cout, sel_ovf;
  logic [15:0] sel_sum;

  always #5 clk = ~clk;

  digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst), .start_i(st16), .sub_i(sub_r),
    .a_i(a_r), .b_i(b_r), .cin_i(cin_r),
    .busy_o(busy16), .done_o(done16), .sum_o(sum16),
    .cout_o(cout16), .ovf_o(ovf16)
  );

  digit_serial_addsub #(.WIDTH(8), .DIGIT(8)) u_dut88 (
    .clk(clk), .rst(rst), .start_i(st88), .sub_i(sub_r),
    .a_i(a_r[7:0]), .b_i(b_r[7:0]), .cin_i(cin_r),
    .busy_o(busy88), .done_o(done88), .sum_o(sum88),
    .cout_o(cout88), .ovf_o(ovf88)
  );

  digit_serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut81 (
    .clk(clk), .rst(rst), .start_i(st81), .sub_i(sub_r),
    .a_i(a_r[7:0]), .b_i(b_r[7:0]), .cin_i(cin_r),
    .busy_o(busy81), .done_o(done81), .sum_o(sum81),
    .cout_o(cout81), .ovf_o(ovf81)
  );

  always_comb begin
    sel_busy = busy16; sel_done = done16; sel_sum = sum16;
    sel_cout = cout16; sel_ovf  = ovf16;
    if (cfg_sel == 1) begin
      sel_busy = busy88; sel_done = done88; sel_sum = {8'h00, sum88};
      sel_cout = cout88; sel_ovf  = ovf88;
    end else if (cfg_sel == 2) begin
      sel_busy = busy81; sel_done = done81; sel_sum = {8'h00, sum81};
      sel_cout = cout81; sel_ovf  = ovf81;
    end
  end

  // Behavioural reference: plain integer arithmetic on a +/- b +/- cin.
  function automatic void model(input int w, input longint a, input longint b,
                                input bit s, input bit c, output longint sm,
                                output bit co, output bit ov);
    longint mask, full, sa, sb, r;
    mask = (64'sd1 <<< w) - 1;
    if (s) full = a + ((~b) & mask) + (c ? 0 : 1);
    else   full = a + b + (c ? 1 : 0);
    sm = full & mask;
    co = ((full >>> w) & 1) != 0;
    sa = (a >= (64'sd1 <<< (w - 1))) ? a - (64'sd1 <<< w) : a;
    sb = (b >= (64'sd1 <<< (w - 1))) ? b - (64'sd1 <<< w) : b;
    r  = s ? (sa - sb - (c ? 1 : 0)) : (sa + sb + (c ? 1 : 0));
    ov = (r > ((64'sd1 <<< (w - 1)) - 1)) || (r < -(64'sd1 <<< (w - 1)));
  endfunction

  // Issues one operation and waits (bounded) for done; returns the result,
  // the number of edges from the accepting edge to done, and busy cycles.
  task automatic run_op(input int cfg, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic c, output logic [15:0] sm,
                        output logic co, output logic ov, output int lat,
                        output int bsy);
    cfg_sel = cfg;
    a_r = a; b_r = b; sub_r = s; cin_r = c;
    case (cfg)
      0:       st16 = 1'b1;
      1:       st88 = 1'b1;
      default: st81 = 1'b1;
    endcase
    @(posedge clk); #1;
    st16 = 1'b0; st88 = 1'b0; st81 = 1'b0;
    lat = 1;
    bsy = sel_busy ? 1 : 0;
    while (!sel_done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (sel_busy) bsy++;
    end
    total++;
    if (!sel_done) begin
      bad++;
      $display("FAIL op_timeout cfg=%0d: done=%b, required 1 within 40 cycles", cfg, sel_done);
    end
    sm = sel_sum; co = sel_cout; ov = sel_ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy16, done16, sum16, cout16, ovf16} !== 19'd0) begin
      bad++;
      $display("FAIL reset_16: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
               busy16, done16, sum16, cout16, ovf16);
    end
    total++;
    if ({busy88, done88, sum88, busy81, done81, sum81} !== 20'd0) begin
      bad++;
      $display("FAIL reset_8: busy88=%b done88=%b sum88=%h busy81=%b done81=%b sum81=%h, required all 0",
               busy88, done88, sum88, busy81, done81, sum81);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [15:0] sm; logic co, ov; int lat, bsy;
    run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, sm, co, ov, lat, bsy);
    total++;
    if ({sm, co, ov} !== {16'h5555, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL add_basic: sum=%h cout=%b ovf=%b, required 5555 0 0", sm, co, ov);
    end
    total++;
    if (lat !== 5) begin
      bad++;
      $display("FAIL add_latency: got %0d, required 5", lat);
    end
    total++;
    if (bsy !== 5) begin
      bad++;
      $display("FAIL add_busy_cycles: got %0d, required 5", bsy);
    end
    total++;
    if (done16 !== 1'b0 || busy16 !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse_width: done=%b busy=%b after DONE, required 0 0", done16, busy16);
    end
  endtask

  task automatic test_add_edges();
    logic [15:0] sm; logic co, ov; int lat, bsy;
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, sm, co, ov, lat, bsy);
    total++;
    if ({sm, co, ov} !== {16'h0000, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL add_carry: sum=%h cout=%b ovf=%b, required 0000 1 0", sm, co, ov);
    end
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, sm, co, ov, lat, bsy);
    total++;
    if ({sm, co, ov} !== {16'h8000, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL add_ovf: sum=%h cout=%b ovf=%b, required 8000 0 1", sm, co, ov);
    end
    run_op(0, 16'h1000, 16'h0FFF, 1'b0, 1'b1, sm, co, ov, lat, bsy);
    total++;
    if ({sm, co, ov} !== {16'h2000, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL add_cin: sum=%h cout=%b ovf=%b, required 2000 0 0", sm, co, ov);
    end
  endtask

  task automatic test_sub();
    logic [15:0] sm; logic co, ov; int lat, bsy;
    run_op(0, 16'h0005, 16'h0007, 1'b1, 1'b0, sm, co, ov, lat, bsy);
    total++;
    if ({sm, co, ov} !== {16'hFFFE, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL sub_borrow: sum=%h cout=%b ovf=%b, required fffe 0 0", sm, co, ov);
    end
    run_op(0, 16'h0005, 16'h0003, 1'b1, 1'b1, sm, co, ov, lat, bsy);
    total++;
    if ({sm, co, ov} !== {16'h0001, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL sub_bin: sum=%h cout=%b ovf=%b, required 0001 1 0", sm, co, ov);
    end
    run_op(0, 16'h8000, 16'h0001, 1'b1, 1'b0, sm, co, ov, lat, bsy);
    total++;
    if ({sm, co, ov} !== {16'h7FFF, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL sub_ovf: sum=%h cout=%b ovf=%b, required 7fff 1 1", sm, co, ov);
    end
  endtask

  task automatic test_ignore_start();
    int n;
    cfg_sel = 0;
    a_r = 16'h1000; b_r = 16'h0234; sub_r = 1'b0; cin_r = 1'b0;
    st16 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0;
    @(posedge clk); #1;
    // A second request mid-run with different operands must be dropped.
    a_r = 16'hFFFF; b_r = 16'hFFFF; sub_r = 1'b1; st16 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0;
    n = 3;
    while (!done16 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (done16 !== 1'b1 || sum16 !== 16'h1234) begin
      bad++;
      $display("FAIL ignore_start_run: done=%b sum=%h, required 1 1234", done16, sum16);
    end
    // Request during the DONE cycle must also be dropped.
    a_r = 16'h5555; b_r = 16'h1111; sub_r = 1'b0; st16 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0;
    total++;
    if (busy16 !== 1'b0 || done16 !== 1'b0) begin
      bad++;
      $display("FAIL ignore_start_done: busy=%b done=%b, required 0 0", busy16, done16);
    end
    @(posedge clk); #1;
    total++;
    if (busy16 !== 1'b0 || sum16 !== 16'h1234) begin
      bad++;
      $display("FAIL ignore_hold: busy=%b sum=%h, required 0 1234", busy16, sum16);
    end
  endtask

  task automatic test_mid_reset();
    logic seen_done;
    cfg_sel = 0;
    a_r = 16'hAAAA; b_r = 16'h1111; sub_r = 1'b0; cin_r = 1'b0;
    st16 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (busy16 !== 1'b0 || done16 !== 1'b0 || sum16 !== 16'h0000) begin
      bad++;
      $display("FAIL mid_reset: busy=%b done=%b sum=%h, required 0 0 0000", busy16, done16, sum16);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done16 || busy16) seen_done = 1'b1;
    end
    total++;
    if (seen_done !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_quiet: activity=%b after reset, required 0", seen_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] sm; logic co, ov; int lat, bsy;
    run_op(0, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, sm, co, ov, lat, bsy);
    total++;
    if ({sm, co, ov} !== {16'h1000, 1'b0, 1'b0} || lat !== 5) begin
      bad++;
      $display("FAIL after_reset: sum=%h cout=%b ovf=%b lat=%0d, required 1000 0 0 5", sm, co, ov, lat);
    end
    run_op(0, 16'h8000, 16'h8000, 1'b0, 1'b0, sm, co, ov, lat, bsy);
    total++;
    if ({sm, co, ov} !== {16'h0000, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL neg_ovf: sum=%h cout=%b ovf=%b, required 0000 1 1", sm, co, ov);
    end
  endtask

  task automatic test_sweep_latency();
    logic [15:0] sm; logic co, ov; int lat, bsy;
    run_op(1, 16'h007F, 16'h0001, 1'b0, 1'b0, sm, co, ov, lat, bsy);
    total++;
    if ({sm[7:0], co, ov} !== {8'h80, 1'b0, 1'b1} || lat !== 2) begin
      bad++;
      $display("FAIL w8d8: sum=%h cout=%b ovf=%b lat=%0d, required 80 0 1 2", sm[7:0], co, ov, lat);
    end
    run_op(2, 16'h00C8, 16'h0064, 1'b1, 1'b0, sm, co, ov, lat, bsy);
    total++;
    if ({sm[7:0], co, ov} !== {8'h64, 1'b1, 1'b1} || lat !== 9) begin
      bad++;
      $display("FAIL w8d1: sum=%h cout=%b ovf=%b lat=%0d, required 64 1 1 9", sm[7:0], co, ov, lat);
    end
  endtask

  task automatic test_random();
    logic [15:0] sm, a, b; logic co, ov, s, c;
    int lat, bsy, w;
    longint esm; bit eco, eov;
    for (int cfg = 0; cfg < 3; cfg++) begin
      w = (cfg == 0) ? 16 : 8;
      for (int k = 0; k < 1000; k++) begin
        a = 16'($urandom) & ((w == 16) ? 16'hFFFF : 16'h00FF);
        b = 16'($urandom) & ((w == 16) ? 16'hFFFF : 16'h00FF);
        s = 1'($urandom);
        c = 1'($urandom);
        model(w, longint'(a), longint'(b), s, c, esm, eco, eov);
        run_op(cfg, a, b, s, c, sm, co, ov, lat, bsy);
        total++;
        if (sm !== 16'(esm) || co !== eco || ov !== eov) begin
          bad++;
          $display("FAIL random cfg=%0d a=%h b=%h sub=%b cin=%b: got %h %b %b, required %h %b %b",
                   cfg, a, b, s, c, sm, co, ov, 16'(esm), eco, eov);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    a_r = '0; b_r = '0; sub_r = 1'b0; cin_r = 1'b0;
    st16 = 1'b0; st88 = 1'b0; st81 = 1'b0;
    test_reset();
    test_add();
    test_add_edges();
    test_sub();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_sweep_latency();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_digit_serial_addsub
`default_nettype wire
